// File: rtl/cache_main_mem_pkg.sv
// Shared definitions for the main-memory model behind the instruction cache.
package cache_main_mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  // Byte address bits below this one select a byte within a 32-bit word.
  localparam int WORD_LSB = 2;
  localparam int DATA_W   = 32;

endpackage

// File: rtl/cache_main_mem_if.sv
// Memory-side request bus between the instruction cache (master) and main memory (slave).
interface cache_main_mem_if;
  import cache_main_mem_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_wr;
  logic [31:0]       mem_req_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_req_ready;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_busy;

  modport master (
    output mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
    input  mem_req_ready, mem_req_data, mem_busy
  );

  modport slave (
    input  mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
    output mem_req_ready, mem_req_data, mem_busy
  );
endinterface

// File: rtl/cache_main_mem_sram_1p.sv
// Single-port synchronous RAM with a registered read port. Contents are zero
// at power-up and are never cleared by rst; only the read register resets.
module mem_sram_1p
  import cache_main_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Read register loads only on a read strobe, otherwise holds the last word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = mem_q[addr];
  end

  // Read register update; reset clears the visible read data.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/cache_main_mem.sv
// Fixed-latency main-memory model: captures one request, waits LATENCY cycles,
// then pulses mem_req_ready for one cycle. Writes commit at the end of that pulse.
module cache_main_mem
  import cache_main_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic             clk,
  input  logic             rst,
  cache_main_mem_if.slave  mem
);

  // Wait-state count loaded at acceptance; unused when LATENCY==1.
  localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  mem_state_e              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;

  logic [ADDR_WIDTH-1:0]   req_idx;
  logic                    ram_we;
  logic                    ram_re;
  logic [DATA_W-1:0]       ram_rdata;
  logic                    unused_addr_bits;

  // Upper and byte-offset address bits are ignored, so addresses alias.
  assign req_idx          = mem.mem_req_addr[ADDR_WIDTH+WORD_LSB-1:WORD_LSB];
  assign unused_addr_bits = ^{mem.mem_req_addr[31:ADDR_WIDTH+WORD_LSB],
                              mem.mem_req_addr[WORD_LSB-1:0]};

  // State and counter register; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured request; only meaningful while a request is outstanding.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  // Next state: accept only in IDLE, count down in WAIT, RESP always returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (mem.mem_req_valid) begin
          addr_d  = req_idx;
          wr_d    = mem.mem_req_wr;
          wdata_d = mem.mem_wr_data;
          if (LATENCY == 1) begin
            state_d = MEM_RESP;
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 8'd0) state_d = MEM_RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // Outputs and RAM strobes: read lands on entry to RESP, write commits at end of RESP.
  always_comb begin
    mem.mem_req_ready = (state_q == MEM_RESP);
    mem.mem_busy      = (state_q != MEM_IDLE);
    ram_re            = (state_d == MEM_RESP) && (state_q != MEM_RESP) && !wr_d;
    ram_we            = (state_q == MEM_RESP) && wr_q && !rst;
    mem.mem_req_data  = ram_rdata;
  end

  mem_sram_1p #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .addr (addr_d),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_cache_main_mem.sv
// Bench for cache_main_mem: directed scenarios plus randomized traffic against
// a cycle-numbered transaction model of the memory.
module tb_cache_main_mem;

  localparam int LAT   = 4;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_main_mem_if bus ();
  cache_main_mem_if bus1 ();

  cache_main_mem #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem(bus)
  );

  cache_main_mem #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem(bus1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // A request sampled in cycle c is answered in cycle c+LAT; its write lands
  // in the model memory at the end of that answer cycle.
  logic [31:0] mdl_mem [DEPTH];
  longint      cyc     = 0;
  bit          pend    = 0;
  longint      rdy_cyc = 0;
  bit          p_wr    = 0;
  int          p_idx   = 0;
  logic [31:0] p_data  = '0;
  logic [31:0] last_rd = '0;

  initial for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      pend    = 0;
      last_rd = '0;
    end else if (pend && rdy_cyc == cyc - 1) begin
      if (p_wr) mdl_mem[p_idx] = p_data;
      else      last_rd        = mdl_mem[p_idx];
      pend = 0;
    end else if (!pend && bus.mem_req_valid) begin
      pend    = 1;
      rdy_cyc = cyc - 1 + LAT;
      p_wr    = bus.mem_req_wr;
      p_idx   = int'((bus.mem_req_addr >> 2) % DEPTH);
      p_data  = bus.mem_wr_data;
    end
  end

  // Every-cycle comparison of the LAT=4 instance against the model.
  always @(negedge clk) begin
    logic        e_rdy, e_busy;
    logic [31:0] e_data;
    e_rdy  = pend && (cyc == rdy_cyc);
    e_busy = pend && (cyc <= rdy_cyc);
    e_data = (e_rdy && !p_wr) ? mdl_mem[p_idx] : last_rd;
    chk("ready", {31'd0, bus.mem_req_ready}, {31'd0, e_rdy});
    chk("busy",  {31'd0, bus.mem_busy},      {31'd0, e_busy});
    chk("data",  bus.mem_req_data,           e_data);
  end

  // Issue one request from a negedge; returns read data and cycles to ready.
  task automatic req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input int alt_at, input logic [31:0] alt_addr, input bit hold,
                     output logic [31:0] rd, output int lat);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_wr    = wr;
    bus.mem_req_addr  = addr;
    bus.mem_wr_data   = data;
    lat = 0;
    rd  = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == alt_at) bus.mem_req_addr = alt_addr;
      if (bus.mem_req_ready) begin
        lat = k;
        rd  = bus.mem_req_data;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no ready within 30 cycles for addr %h", addr);
    end
    if (!hold) bus.mem_req_valid = 1'b0;
  endtask

  function automatic int count_ready_start();
    return 0;
  endfunction

  initial begin
    logic [31:0] rd;
    int          lat, pulses;
    bit          hold;
    int          gap, alt;
    logic [31:0] a;

    bus.mem_req_valid  = 1'b0;
    bus.mem_req_wr     = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_wr_data    = '0;
    bus1.mem_req_valid = 1'b0;
    bus1.mem_req_wr    = 1'b0;
    bus1.mem_req_addr  = '0;
    bus1.mem_wr_data   = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_ready", {31'd0, bus.mem_req_ready}, 32'd0);
    chk("idle_busy",  {31'd0, bus.mem_busy},      32'd0);
    chk("idle_data",  bus.mem_req_data,           32'd0);

    // Write then read with fixed latency.
    req(1'b1, 32'h40, 32'hDEADBEEF, 0, '0, 1'b0, rd, lat);
    chk("wr_latency", 32'(lat), 32'd4);
    @(negedge clk);
    req(1'b0, 32'h40, '0, 0, '0, 1'b0, rd, lat);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);

    // WriteBack then Allocate with valid held across the ready pulse.
    @(negedge clk);
    req(1'b1, 32'h80, 32'h11111111, 0, '0, 1'b1, rd, lat);
    chk("wb_latency", 32'(lat), 32'd4);
    req(1'b0, 32'h80, '0, 0, '0, 1'b0, rd, lat);
    chk("alloc_latency", 32'(lat), 32'd5);
    chk("alloc_data", rd, 32'h11111111);
    pulses = count_ready_start();
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_req_ready) pulses++;
    end
    chk("no_double_accept", 32'(pulses), 32'd0);

    // Address changes while waiting are ignored.
    req(1'b1, 32'h44, 32'h0BADF00D, 0, '0, 1'b0, rd, lat);
    @(negedge clk);
    req(1'b0, 32'h40, '0, 2, 32'h44, 1'b0, rd, lat);
    chk("addr_held", rd, 32'hDEADBEEF);

    // Aliasing of upper and byte-offset address bits.
    @(negedge clk);
    req(1'b1, 32'h0000_1004, 32'hA5A5A5A5, 0, '0, 1'b0, rd, lat);
    @(negedge clk);
    req(1'b0, 32'h0000_0004, '0, 0, '0, 1'b0, rd, lat);
    chk("alias_hi", rd, 32'hA5A5A5A5);
    @(negedge clk);
    req(1'b0, 32'h0000_0007, '0, 0, '0, 1'b0, rd, lat);
    chk("alias_lo", rd, 32'hA5A5A5A5);

    // Reset during the wait of a write: no pulse, write discarded.
    @(negedge clk);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_wr    = 1'b1;
    bus.mem_req_addr  = 32'h20;
    bus.mem_wr_data   = 32'h12345678;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_req_valid = 1'b0;
    chk("rst_busy", {31'd0, bus.mem_busy}, 32'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_req_ready) pulses++;
    end
    chk("rst_no_ready", 32'(pulses), 32'd0);
    req(1'b0, 32'h20, '0, 0, '0, 1'b0, rd, lat);
    chk("rst_no_commit", rd, 32'h0);

    // LATENCY=1 instance: ready the cycle after acceptance.
    bus1.mem_req_valid = 1'b1;
    bus1.mem_req_wr    = 1'b1;
    bus1.mem_req_addr  = 32'h40;
    bus1.mem_wr_data   = 32'h5A5A0001;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus1.mem_req_ready) begin lat = k; break; end
    end
    bus1.mem_req_valid = 1'b0;
    chk("lat1_wr_latency", 32'(lat), 32'd1);
    @(negedge clk);
    chk("lat1_pulse_width", {31'd0, bus1.mem_req_ready}, 32'd0);
    bus1.mem_req_valid = 1'b1;
    bus1.mem_req_wr    = 1'b0;
    lat = 0;
    rd  = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus1.mem_req_ready) begin lat = k; rd = bus1.mem_req_data; break; end
    end
    bus1.mem_req_valid = 1'b0;
    chk("lat1_rd_latency", 32'(lat), 32'd1);
    chk("lat1_rd_data", rd, 32'h5A5A0001);

    // Randomized traffic over a small word window to provoke read-after-write hits.
    hold = 1'b0;
    for (int n = 0; n < 300; n++) begin
      gap = hold ? 0 : int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      alt  = int'($urandom_range(0, 3));
      hold = ($urandom_range(0, 2) == 0);
      req($urandom_range(0, 1) == 1, a, $urandom, alt, $urandom, hold, rd, lat);
    end
    bus.mem_req_valid = 1'b0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
